gpio_input_conditioner: RTL and testbench

// Conditions the raw board buttons and switches before they reach the PS GPIO input bus.
// Per channel: synchronizes to clk, debounces, presents a clean level, and latches sticky

---
 rtl/gpio_input_conditioner.sv | 91 +++++++++
 tb/tb_gpio_input_conditioner.sv | 247 ++++++++++++++++++++++++
 2 files changed

// File: rtl/gpio_input_conditioner.sv
// gpio_input_conditioner
// Per-channel input conditioning for board buttons and switches feeding the PS GPIO
// input bus: a flip-flop synchronizer, a debounce counter that only accepts a new level
// once it has persisted long enough, and sticky rise/fall event bits that software
// clears through per-bit strobes. irq is the OR of every pending event bit.
module gpio_input_conditioner #(
  parameter int NUM_INPUTS      = 6,
  parameter int SYNC_STAGES     = 2,
  parameter int DEBOUNCE_CYCLES = 100000
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic [NUM_INPUTS-1:0] raw_in,
  input  logic [NUM_INPUTS-1:0] clear_rise,
  input  logic [NUM_INPUTS-1:0] clear_fall,
  output logic [NUM_INPUTS-1:0] clean,
  output logic [NUM_INPUTS-1:0] rise_pending,
  output logic [NUM_INPUTS-1:0] fall_pending,
  output logic                  irq
);

  // Counter only has to reach DEBOUNCE_CYCLES-1, so $clog2 bits are sufficient.
  localparam int              CNT_W   = $clog2(DEBOUNCE_CYCLES);
  localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(DEBOUNCE_CYCLES - 1);

  genvar gi;
  generate
    for (gi = 0; gi < NUM_INPUTS; gi++) begin : g_chan
      logic [SYNC_STAGES-1:0] sync_reg;
      logic                   sync_bit;
      logic [CNT_W-1:0]       count_reg;
      logic [CNT_W-1:0]       count_next;
      logic                   clean_reg;
      logic                   clean_next;
      logic                   rise_reg;
      logic                   rise_next;
      logic                   fall_reg;
      logic                   fall_next;

      // Synchronizer chain: the raw pin goes straight into the first flop.
      always_ff @(posedge clk) begin
        if (reset) begin
          sync_reg <= '0;
        end else begin
          sync_reg <= {sync_reg[SYNC_STAGES-2:0], raw_in[gi]};
        end
      end

      assign sync_bit = sync_reg[SYNC_STAGES-1];

      // Debounce and event decode: any sample agreeing with clean restarts the qualification.
      always_comb begin
        count_next = count_reg;
        clean_next = clean_reg;
        if (sync_bit == clean_reg) begin
          count_next = '0;
        end else if (count_reg == CNT_MAX) begin
          clean_next = sync_bit;
          count_next = '0;
        end else begin
          count_next = count_reg + 1'b1;
        end
        // A new event on the same edge as a clear strobe keeps the bit set.
        rise_next = (clean_next & ~clean_reg) | (rise_reg & ~clear_rise[gi]);
        fall_next = (~clean_next & clean_reg) | (fall_reg & ~clear_fall[gi]);
      end

      // Channel state registers.
      always_ff @(posedge clk) begin
        if (reset) begin
          count_reg <= '0;
          clean_reg <= 1'b0;
          rise_reg  <= 1'b0;
          fall_reg  <= 1'b0;
        end else begin
          count_reg <= count_next;
          clean_reg <= clean_next;
          rise_reg  <= rise_next;
          fall_reg  <= fall_next;
        end
      end

      assign clean[gi]        = clean_reg;
      assign rise_pending[gi] = rise_reg;
      assign fall_pending[gi] = fall_reg;
    end
  endgenerate

  assign irq = |(rise_pending | fall_pending);

endmodule

// File: tb/tb_gpio_input_conditioner.sv
// tb_gpio_input_conditioner
// Directed scenarios plus a randomized phase. A reference model derived from the
// behavioural rules (a level is accepted once the synchronized input has disagreed
// with the clean level for DEBOUNCE_CYCLES consecutive edges) is stepped on every
// clock edge and compared against all outputs.
module tb_gpio_input_conditioner;
  localparam int N = 6;
  localparam int S = 2;
  localparam int D = 8;
  localparam int LAT = S + D;

  logic         clk = 1'b0;
  logic         reset = 1'b1;
  logic [N-1:0] raw_in = '0;
  logic [N-1:0] clear_rise = '0;
  logic [N-1:0] clear_fall = '0;
  logic [N-1:0] clean;
  logic [N-1:0] rise_pending;
  logic [N-1:0] fall_pending;
  logic         irq;

  gpio_input_conditioner #(
    .NUM_INPUTS(N), .SYNC_STAGES(S), .DEBOUNCE_CYCLES(D)
  ) dut (
    .clk(clk), .reset(reset), .raw_in(raw_in),
    .clear_rise(clear_rise), .clear_fall(clear_fall),
    .clean(clean), .rise_pending(rise_pending), .fall_pending(fall_pending), .irq(irq)
  );

  always #5 clk = ~clk;

  int n_checks = 0;
  int n_pass = 0;

  // Reference model state: delayed raw samples, history of synchronized samples seen.
  bit m_pipe [N][S];
  bit m_hist [N][D];
  bit m_clean [N];
  bit m_rise [N];
  bit m_fall [N];

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, got, exp, $time);
  endtask

  function automatic void model_step();
    for (int ch = 0; ch < N; ch++) begin
      if (reset) begin
        for (int i = 0; i < S; i++) m_pipe[ch][i] = 1'b0;
        for (int i = 0; i < D; i++) m_hist[ch][i] = 1'b0;
        m_clean[ch] = 1'b0;
        m_rise[ch]  = 1'b0;
        m_fall[ch]  = 1'b0;
      end else begin
        bit s;
        bit all_diff;
        bit nc;
        s = m_pipe[ch][S-1];
        for (int i = D - 1; i > 0; i--) m_hist[ch][i] = m_hist[ch][i-1];
        m_hist[ch][0] = s;
        all_diff = 1'b1;
        for (int i = 0; i < D; i++) if (m_hist[ch][i] == m_clean[ch]) all_diff = 1'b0;
        nc = all_diff ? ~m_clean[ch] : m_clean[ch];
        m_rise[ch] = (nc & ~m_clean[ch]) | (m_rise[ch] & ~clear_rise[ch]);
        m_fall[ch] = (~nc & m_clean[ch]) | (m_fall[ch] & ~clear_fall[ch]);
        for (int i = S - 1; i > 0; i--) m_pipe[ch][i] = m_pipe[ch][i-1];
        m_pipe[ch][0] = raw_in[ch];
        m_clean[ch] = nc;
      end
    end
  endfunction

  // One clock edge: step the model with the inputs the DUT saw, then compare outputs.
  task automatic tick();
    logic [N-1:0] ec, er, ef;
    @(posedge clk);
    model_step();
    #1;
    for (int ch = 0; ch < N; ch++) begin
      ec[ch] = m_clean[ch];
      er[ch] = m_rise[ch];
      ef[ch] = m_fall[ch];
    end
    check("clean", 32'(clean), 32'(ec));
    check("rise_pending", 32'(rise_pending), 32'(er));
    check("fall_pending", 32'(fall_pending), 32'(ef));
    check("irq", 32'(irq), 32'(|(er | ef)));
  endtask

  task automatic ticks(input int n);
    for (int i = 0; i < n; i++) tick();
  endtask

  task automatic wait_clean(input int ch, input logic val, output int lat);
    lat = 0;
    while (clean[ch] !== val && lat < 4 * LAT) begin
      tick();
      lat++;
    end
    if (clean[ch] !== val) check("wait_clean_timeout", 32'(clean[ch]), 32'(val));
  endtask

  initial begin
    int lat;
    int rises;
    logic prev;

    // Reset state
    ticks(3);
    check("reset_clean", 32'(clean), 32'h0);
    check("reset_irq", 32'(irq), 32'h0);
    reset = 1'b0;
    ticks(2);

    // 1: single rising step, exact latency
    raw_in[0] = 1'b1;
    wait_clean(0, 1'b1, lat);
    check("s1_latency", 32'(lat), 32'(LAT));
    check("s1_rise0", 32'(rise_pending[0]), 32'h1);
    check("s1_irq", 32'(irq), 32'h1);
    $display("scenario 1: clean[0] rose after %0d edges", lat);

    // 2: bouncing input, then settles high
    rises = 0;
    for (int k = 0; k < 10; k++) begin
      raw_in[1] = ~raw_in[1];
      for (int j = 0; j < 3; j++) begin
        prev = clean[1];
        tick();
        if (!prev && clean[1]) rises++;
      end
    end
    raw_in[1] = 1'b1;
    lat = 0;
    while (lat < 4 * LAT) begin
      prev = clean[1];
      tick();
      lat++;
      if (!prev && clean[1]) begin
        rises++;
        break;
      end
    end
    check("s2_latency", 32'(lat), 32'(LAT));
    ticks(12);
    check("s2_rise_count", 32'(rises), 32'h1);
    check("s2_rise1", 32'(rise_pending[1]), 32'h1);
    check("s2_fall1", 32'(fall_pending[1]), 32'h0);
    $display("scenario 2: %0d rise(s), final latency %0d", rises, lat);

    // 3: pulse one cycle too short
    raw_in[2] = 1'b1;
    ticks(D - 1);
    raw_in[2] = 1'b0;
    ticks(20);
    check("s3_clean2", 32'(clean[2]), 32'h0);
    check("s3_rise2", 32'(rise_pending[2]), 32'h0);
    check("s3_fall2", 32'(fall_pending[2]), 32'h0);
    $display("scenario 3: short pulse on channel 2 rejected");

    // 4: clear racing a new rise event
    raw_in[3] = 1'b1;
    wait_clean(3, 1'b1, lat);
    raw_in[3] = 1'b0;
    wait_clean(3, 1'b0, lat);
    raw_in[3] = 1'b1;
    ticks(LAT - 1);
    clear_rise[3] = 1'b1;
    tick();
    clear_rise[3] = 1'b0;
    check("s4_clean3", 32'(clean[3]), 32'h1);
    check("s4_set_wins", 32'(rise_pending[3]), 32'h1);
    clear_rise = 6'h37;
    clear_fall = 6'h3F;
    tick();
    clear_rise = '0;
    clear_fall = '0;
    check("s4_only_rise3", 32'(rise_pending), 32'h08);
    clear_rise[3] = 1'b1;
    tick();
    clear_rise[3] = 1'b0;
    check("s4_rise3_cleared", 32'(rise_pending[3]), 32'h0);
    check("s4_irq", 32'(irq), 32'h0);
    $display("scenario 4: set wins over clear, lone clear drops rise_pending[3]");

    // 5: reset in the middle of qualification
    raw_in[4] = 1'b1;
    ticks(S + 5);
    reset = 1'b1;
    tick();
    check("s5_clean", 32'(clean), 32'h0);
    check("s5_rise", 32'(rise_pending), 32'h0);
    check("s5_fall", 32'(fall_pending), 32'h0);
    check("s5_irq", 32'(irq), 32'h0);
    reset = 1'b0;
    wait_clean(4, 1'b1, lat);
    check("s5_latency", 32'(lat), 32'(LAT));
    $display("scenario 5: clean[4] requalified %0d edges after reset release", lat);

    // 6: all channels together
    raw_in = '0;
    ticks(LAT + 5);
    clear_rise = 6'h3F;
    clear_fall = 6'h3F;
    tick();
    clear_rise = '0;
    clear_fall = '0;
    check("s6_idle_irq", 32'(irq), 32'h0);
    raw_in = 6'h3F;
    lat = 0;
    while (clean == '0 && lat < 4 * LAT) begin
      tick();
      lat++;
    end
    check("s6_latency", 32'(lat), 32'(LAT));
    check("s6_clean_all", 32'(clean), 32'h3F);
    check("s6_rise_all", 32'(rise_pending), 32'h3F);
    check("s6_irq_set", 32'(irq), 32'h1);
    clear_rise = 6'h3F;
    tick();
    clear_rise = '0;
    check("s6_rise_cleared", 32'(rise_pending), 32'h0);
    check("s6_irq_clear", 32'(irq), 32'h0);
    $display("scenario 6: all channels rose together after %0d edges", lat);

    // Randomized phase: sparse level changes, random clears, rare resets
    for (int c = 0; c < 2000; c++) begin
      for (int ch = 0; ch < N; ch++) begin
        if ($urandom_range(0, 11) == 0) raw_in[ch] = ~raw_in[ch];
        clear_rise[ch] = ($urandom_range(0, 7) == 0);
        clear_fall[ch] = ($urandom_range(0, 7) == 0);
      end
      reset = ($urandom_range(0, 499) == 0);
      tick();
    end
    reset = 1'b0;
    clear_rise = '0;
    clear_fall = '0;
    ticks(LAT + 2);
    $display("random phase: 2000 cycles compared against reference model");

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end
endmodule
